// File: rtl/mm_pkg.sv
// Shared constants and types for the matrix-multiplier product sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: result-matrix geometry, element/product/accumulator widths,
// the sequencer state encoding and a small overflow helper.
package mm_pkg;

  localparam int ROWS        = 2;
  localparam int COLS        = 4;
  localparam int ELEM_W      = 8;
  localparam int NUM_ENTRIES = ROWS * COLS;

  // Result entry index i*COLS+j spans 0..7.
  localparam int IDX_W = 3;

  // Inner-dimension counter; K is limited to 1..8, so 3 bits always suffice.
  localparam int K_W = 3;

  // An 8x8 product is 16 bits; summing up to 8 of them needs 3 more bits.
  localparam int PROD_W = 2 * ELEM_W;
  localparam int ACC_W  = PROD_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // True when an accumulated element no longer fits in one result byte.
  function automatic logic acc_overflows(input logic [ACC_W-1:0] acc);
    return (acc >= ACC_W'(1 << ELEM_W));
  endfunction

endpackage

// File: rtl/mm_mac_unit.sv
// Single multiply-accumulate lane: acc += a*b when en, acc := 0 when clear.
// Latency: acc_sum is combinational (acc + a*b); acc updates one clock later.
// Backpressure: none; en/clear are sampled every cycle.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   clear           synchronous clear of the accumulator (wins over en)
//   en              add a*b into the accumulator this cycle
//   a, b            unsigned 8-bit operands
//   acc_sum         accumulator plus current product, before registering
module mm_mac_unit
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ACC_W-1:0]  acc_sum
);

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [PROD_W-1:0] prod;

  always_comb begin
    prod    = a * b;
    acc_sum = acc_q + {{(ACC_W-PROD_W){1'b0}}, prod};
    acc_d   = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mm_product_sequencer.sv
// Computes C = A(2xK) * B(Kx4) one element at a time and streams each byte to
// the result register file as a one-cycle (value, index) write strobe.
// Latency: start to done is 8K+9 cycles; entry e is written in cycle (e+1)(K+1).
// Backpressure: none; start is ignored while busy, writes are fire-and-forget.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           begin a run (sampled only when idle)
//   a_flat          A row-major, A[i][k] at byte i*K+k
//   b_flat          B row-major, B[k][j] at byte k*4+j
//   busy            high from the cycle after start through the done cycle
//   done            one-cycle pulse after the eighth write
//   product_out     result byte (held between writes)
//   reg_specifier   result entry index i*4+j (held between writes)
//   update_reg      one-cycle write strobe
//   overflow        sticky: some element of this run was >= 256
module mm_product_sequencer
  import mm_pkg::*;
#(
  parameter int K = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ROWS*K*ELEM_W-1:0]   a_flat,
  input  logic [K*COLS*ELEM_W-1:0]   b_flat,
  output logic                       busy,
  output logic                       done,
  output logic [ELEM_W-1:0]          product_out,
  output logic [IDX_W-1:0]           reg_specifier,
  output logic                       update_reg,
  output logic                       overflow
);

  if (K < 1 || K > 8) begin : g_bad_k
    $error("mm_product_sequencer: K must be in 1..8");
  end

  localparam logic [K_W-1:0]   K_LAST   = K_W'(K - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

  state_e                     state_q, state_d;
  logic [K_W-1:0]             k_q, k_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [ROWS*K*ELEM_W-1:0]   a_q, a_d;
  logic [K*COLS*ELEM_W-1:0]   b_q, b_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       update_reg_q, update_reg_d;
  logic [ELEM_W-1:0]          product_out_q, product_out_d;
  logic [IDX_W-1:0]           reg_specifier_q, reg_specifier_d;
  logic                       overflow_q, overflow_d;

  logic                       mac_en;
  logic                       mac_clr;
  logic [ELEM_W-1:0]          a_sel;
  logic [ELEM_W-1:0]          b_sel;
  logic [ACC_W-1:0]           mac_sum;

  // Operand selection: row = idx/4 (top index bit), column = idx%4 (low bits).
  // Loops compare against constants so every part-select has a fixed base.
  always_comb begin
    a_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int kk = 0; kk < K; kk++) begin
        if (idx_q[IDX_W-1] == 1'(r) && k_q == K_W'(kk)) begin
          a_sel = a_q[(r*K + kk)*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  always_comb begin
    b_sel = '0;
    for (int kk = 0; kk < K; kk++) begin
      for (int c = 0; c < COLS; c++) begin
        if (k_q == K_W'(kk) && idx_q[1:0] == 2'(c)) begin
          b_sel = b_q[(kk*COLS + c)*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  mm_mac_unit u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear   (mac_clr),
    .en      (mac_en),
    .a       (a_sel),
    .b       (b_sel),
    .acc_sum (mac_sum)
  );

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    idx_d           = idx_q;
    a_d             = a_q;
    b_d             = b_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    update_reg_d    = 1'b0;
    product_out_d   = product_out_q;
    reg_specifier_d = reg_specifier_q;
    overflow_d      = overflow_q;
    mac_en          = 1'b0;
    mac_clr         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = a_flat;
          b_d        = b_flat;
          k_d        = '0;
          idx_d      = '0;
          overflow_d = 1'b0;
          mac_clr    = 1'b1;
          busy_d     = 1'b1;
          state_d    = MAC;
        end
      end

      MAC: begin
        mac_en = 1'b1;
        if (k_q == K_LAST) begin
          // The final sum is only available combinationally here, so the
          // write outputs are registered on entry to WRITE and stay stable
          // for the whole strobe cycle and until the next write.
          update_reg_d    = 1'b1;
          product_out_d   = mac_sum[ELEM_W-1:0];
          reg_specifier_d = idx_q;
          if (acc_overflows(mac_sum)) begin
            overflow_d = 1'b1;
          end
          k_d     = '0;
          state_d = WRITE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end

      WRITE: begin
        mac_clr = 1'b1;
        k_d     = '0;
        if (idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = MAC;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      k_q             <= '0;
      idx_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      update_reg_q    <= 1'b0;
      product_out_q   <= '0;
      reg_specifier_q <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      idx_q           <= idx_d;
      a_q             <= a_d;
      b_q             <= b_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      update_reg_q    <= update_reg_d;
      product_out_q   <= product_out_d;
      reg_specifier_q <= reg_specifier_d;
      overflow_q      <= overflow_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign update_reg    = update_reg_q;
  assign product_out   = product_out_q;
  assign reg_specifier = reg_specifier_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_mm_product_sequencer.sv
// Scoreboard bench for mm_product_sequencer (K=4 and K=1 instances).
// Stimulus pushes expected writes/done pulses; monitors pop and compare.
module tb_mm_product_sequencer;

  typedef struct {
    int         cyc;
    logic [2:0] idx;
    logic [7:0] val;
    logic       ovf;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // K=4 instance
  logic         start4 = 1'b0;
  logic [63:0]  a_flat4 = '0;
  logic [127:0] b_flat4 = '0;
  logic         busy4, done4, upd4, ovf4;
  logic [7:0]   prod4;
  logic [2:0]   spec4;

  mm_product_sequencer #(.K(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a_flat(a_flat4), .b_flat(b_flat4),
    .busy(busy4), .done(done4), .product_out(prod4), .reg_specifier(spec4),
    .update_reg(upd4), .overflow(ovf4)
  );

  // K=1 instance
  logic         start1 = 1'b0;
  logic [15:0]  a_flat1 = '0;
  logic [31:0]  b_flat1 = '0;
  logic         busy1, done1, upd1, ovf1;
  logic [7:0]   prod1;
  logic [2:0]   spec1;

  mm_product_sequencer #(.K(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a_flat(a_flat1), .b_flat(b_flat1),
    .busy(busy1), .done(done1), .product_out(prod1), .reg_specifier(spec1),
    .update_reg(upd1), .overflow(ovf1)
  );

  wr_t wq4[$];
  wr_t wq1[$];
  int  dq4[$];
  int  dq1[$];
  int  base4 = 0;
  int  base1 = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  task automatic mon_write(input string nm, input int have, input wr_t e,
                           input logic [2:0] idx, input logic [7:0] v, input logic o);
    checks++;
    if (have == 0) begin
      failures++;
      $display("FAIL %s unexpected write: idx=%0d val=%0h at cycle %0d", nm, idx, v, cyc);
    end else if (e.cyc != cyc || e.idx != idx || e.val != v || e.ovf != o) begin
      failures++;
      $display("FAIL %s write: got cyc=%0d idx=%0d val=%0h ovf=%0b expected cyc=%0d idx=%0d val=%0h ovf=%0b",
               nm, cyc, idx, v, o, e.cyc, e.idx, e.val, e.ovf);
    end
  endtask

  task automatic mon_done(input string nm, input int have, input int ecyc);
    checks++;
    if (have == 0) begin
      failures++;
      $display("FAIL %s unexpected done at cycle %0d", nm, cyc);
    end else if (ecyc != cyc) begin
      failures++;
      $display("FAIL %s done: got cycle %0d expected %0d", nm, cyc, ecyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    int  d;
    e = '{cyc: 0, idx: 3'd0, val: 8'd0, ovf: 1'b0};
    d = 0;
    if (upd4 === 1'b1) begin
      if (wq4.size() > 0) begin
        e = wq4.pop_front();
        mon_write("k4", 1, e, spec4, prod4, ovf4);
      end else begin
        mon_write("k4", 0, e, spec4, prod4, ovf4);
      end
    end
    if (done4 === 1'b1) begin
      if (dq4.size() > 0) begin
        d = dq4.pop_front();
        mon_done("k4", 1, d);
      end else begin
        mon_done("k4", 0, 0);
      end
    end
    if (upd1 === 1'b1) begin
      if (wq1.size() > 0) begin
        e = wq1.pop_front();
        mon_write("k1", 1, e, spec1, prod1, ovf1);
      end else begin
        mon_write("k1", 0, e, spec1, prod1, ovf1);
      end
    end
    if (done1 === 1'b1) begin
      if (dq1.size() > 0) begin
        d = dq1.pop_front();
        mon_done("k1", 1, d);
      end else begin
        mon_done("k1", 0, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; that cycle is "cycle 0" of the run.
  task automatic run4(input logic [63:0] a, input logic [127:0] b,
                      input logic [63:0] vals, input logic o, input int nwr);
    wr_t e;
    a_flat4 = a;
    b_flat4 = b;
    start4  = 1'b1;
    base4   = cyc;
    for (int i = 0; i < nwr; i++) begin
      e.cyc = base4 + (i + 1) * 5;
      e.idx = 3'(i);
      e.val = vals[i*8 +: 8];
      e.ovf = o;
      wq4.push_back(e);
    end
    if (nwr == 8) dq4.push_back(base4 + 41);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait4(input int n);
    while (cyc - base4 < n) @(negedge clk);
  endtask

  localparam logic [63:0]  A_ROWS   = 64'h0807060504030201;
  localparam logic [127:0] B_IDENT  = 128'h01000000_00010000_00000100_00000001;
  localparam logic [63:0]  V_IDENT  = 64'h0807060504030201;

  initial begin
    wr_t e;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", busy4, 0);
    chk("reset done", done4, 0);
    chk("reset update_reg", upd4, 0);
    chk("reset product_out", prod4, 0);
    chk("reset reg_specifier", spec4, 0);
    chk("reset overflow", ovf4, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: identity B, values 1..8
    run4(A_ROWS, B_IDENT, V_IDENT, 1'b0, 8);
    wait4(42);
    chk("ident overflow", ovf4, 0);

    // 2: all ones, busy window check
    run4({8{8'h01}}, {16{8'h01}}, {8{8'h04}}, 1'b0, 8);
    for (int n = 1; n <= 43; n++) begin
      wait4(n);
      chk($sformatf("busy cyc%0d", n), busy4, (n >= 1 && n <= 41) ? 1 : 0);
    end

    // 3: all 0xFF, overflow sticky
    run4({8{8'hFF}}, {16{8'hFF}}, {8{8'h04}}, 1'b1, 8);
    wait4(4);
    chk("ff overflow before first write", ovf4, 0);
    wait4(42);
    chk("ff overflow sticky after done", ovf4, 1);

    // 4: operands change mid-run, start while busy ignored; start clears overflow
    run4(A_ROWS, B_IDENT, V_IDENT, 1'b0, 8);
    chk("restart clears overflow", ovf4, 0);
    wait4(2);
    a_flat4 = '0;
    b_flat4 = '0;
    wait4(7);
    start4 = 1'b1;
    wait4(8);
    start4 = 1'b0;
    wait4(43);

    // 5: reset mid-run during third entry
    run4(A_ROWS, B_IDENT, V_IDENT, 1'b0, 2);
    wait4(12);
    reset = 1'b1;
    wait4(13);
    chk("midreset busy", busy4, 0);
    chk("midreset done", done4, 0);
    chk("midreset update_reg", upd4, 0);
    chk("midreset product_out", prod4, 0);
    chk("midreset reg_specifier", spec4, 0);
    chk("midreset overflow", ovf4, 0);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("midreset still idle", busy4, 0);
    run4(A_ROWS, B_IDENT, V_IDENT, 1'b0, 8);
    wait4(43);

    // 6: K=1, all 0x03
    a_flat1 = {2{8'h03}};
    b_flat1 = {4{8'h03}};
    start1  = 1'b1;
    base1   = cyc;
    for (int i = 0; i < 8; i++) begin
      e.cyc = base1 + (i + 1) * 2;
      e.idx = 3'(i);
      e.val = 8'h09;
      e.ovf = 1'b0;
      wq1.push_back(e);
    end
    dq1.push_back(base1 + 17);
    @(negedge clk);
    start1 = 1'b0;
    while (cyc - base1 < 20) @(negedge clk);
    chk("k1 busy after done", busy1, 0);

    chk("k4 writes outstanding", wq4.size(), 0);
    chk("k4 done outstanding", dq4.size(), 0);
    chk("k1 writes outstanding", wq1.size(), 0);
    chk("k1 done outstanding", dq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_product_sequencer.md
# mm_product_sequencer

Upstream compute stage of the matrix multiplier. It computes C = A × B, with A of 2×K and B of K×4 (unsigned 8-bit elements), one output element at a time on a single multiply-accumulate datapath. It streams the 8 results as single-cycle write strobes (value, index) into the 8-entry × 8-bit result register file. It signals completion once all 8 writes have been issued.

## Interface
Parameters:
- K, default 4: inner dimension; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- a_flat  in  2*K*8  A row-major; A[i][k] = a_flat[(i*K+k)*8 +: 8].
- b_flat  in  K*4*8  B row-major; B[k][j] = b_flat[(k*4+j)*8 +: 8].
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse when all 8 writes have been issued.
- product_out  out  8  result byte; drives the register file product_in.
- reg_specifier  out  3  entry index i*4+j (0..7); drives the register file reg_specifier.
- update_reg  out  1  one-cycle write strobe; drives the register file update_reg.
- overflow  out  1  sticky; set when any accumulated element is ≥ 256 in the current run.

## Operation
- FSM states: IDLE, MAC, WRITE, DONE.
- **IDLE**
  - start=1: capture a_flat and b_flat into internal operand registers, clear the accumulator, set idx=0 and k=0, clear overflow, go to MAC.
  - After capture, input operands may change freely.
- **MAC**
  - Each cycle: acc += A[idx/4][k] * B[k][idx%4], then k++.
  - When k == K-1, go to WRITE.
- **WRITE**, held for exactly one cycle:
  - update_reg=1, product_out=acc[7:0], reg_specifier=idx.
  - If acc ≥ 256, set overflow.
  - Then clear acc and k. If idx==7 go to DONE; otherwise idx++ and go to MAC.
- **DONE**, held for exactly one cycle: done=1, then go to IDLE.
- Arithmetic:
  - Unsigned throughout.
  - Products are 16 bits; the accumulator is 16+3 bits, so it cannot wrap for K ≤ 8.
  - Output is truncated to the low 8 bits; no saturation.
- product_out and reg_specifier are registered. They change only on entry to WRITE and hold their value until the next WRITE. The downstream register file is level-sensitive, so these must stay stable around the update_reg edges.
- update_reg, done and busy are registered and glitch-free.
- start while busy: ignored, with no effect on the run in progress.
- Reset (any state, including mid-run):
  - Next cycle: state IDLE, busy=0, done=0, update_reg=0, product_out=0, reg_specifier=0, overflow=0, acc=0.
  - No further writes are issued.
  - Register file entries already written are not this block's concern; the register file shares reset.

## Timing
- start is sampled high in cycle 0.
- MAC for entry e occupies cycles e*(K+1)+1 .. e*(K+1)+K.
- update_reg for entry e is high in cycle (e+1)*(K+1).
- done is high in cycle 8*(K+1)+1; busy is high in cycles 1 .. 8*(K+1)+1.
- The earliest next start is accepted in cycle 8*(K+1)+2.
- Total latency from start to done: 8K+9 cycles. With K=4 that is 41 cycles, and writes occur at cycles 5, 10, …, 40.
- overflow is updated in the same cycle as the offending update_reg and stays valid until the next accepted start or reset.

## Structure
- Shared package mm_pkg, holding:
  - ROWS=2, COLS=4, ELEM_W=8, NUM_ENTRIES=8;
  - the state enum (IDLE/MAC/WRITE/DONE);
  - the index width constant (3).
- Sub-module mm_mac_unit: 8×8 unsigned multiply plus 19-bit accumulate, with synchronous clear and enable inputs.
- The sequencer owns the FSM, the operand capture registers, the k and idx counters, and the operand selection muxes.

## Test plan
- A rows [1,2,3,4] / [5,6,7,8], B = 4×4 identity, K=4:
  - writes of idx 0..7 carry values 1..8, at cycles 5, 10, …, 40;
  - done at cycle 41; overflow=0.
- A and B all 0x01, K=4: all eight writes carry 0x04; busy is high in cycles 1–41 exactly.
- A and B all 0xFF, K=4: each write carries 0x04 (260100 mod 256); overflow rises at cycle 5 and stays high; the next start clears it.
- Change a_flat/b_flat to 0 in cycle 2, and pulse start again in cycle 7: results are unchanged from the first scenario, and the second start is ignored (exactly 8 writes, one done).
- Assert reset in cycle 12 during the third entry's MAC:
  - in cycle 13 all outputs are 0 and state is IDLE;
  - no update_reg occurs afterwards;
  - a fresh start then completes normally with the first scenario's values.
- K=1, A and B all 0x03: writes carry 0x09 at cycles 2, 4, …, 16; done at cycle 17.
